// File: rtl/channel_arbiter_pkg.sv
// ============================================================================
// Module      : channel_arbiter_pkg
// Description : Shared FSM encodings and pointer-width helper for channel_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package channel_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  // Width of a pointer addressing n requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/channel_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search starting one past `last`.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
  import channel_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int LW = ptr_width(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [LW-1:0] last,
  output logic          valid,
  output logic [LW-1:0] winner
);

  logic [LW-1:0] idx;

  // The previous winner is visited last, so it only wins again when alone.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = last;
    for (int k = 0; k < N; k++) begin
      idx = (idx == LW'(N - 1)) ? '0 : idx + 1'b1;
      if (!valid && pending[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/channel_arbiter.sv
// ============================================================================
// Module      : channel_arbiter
// Description : Round-robin arbiter sharing one two-phase output channel among
//               N two-phase requesters. Define ARB_DEBUG_EN for grant/release
//               trace lines in simulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_arbiter
  import channel_arbiter_pkg::*;
#(
  parameter int ID   = -1,
  parameter     PORT = "unknown",
  parameter int SIZE = 8,
  parameter int N    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_in,
  output logic [N-1:0]      ack_in,
  input  logic [N*SIZE-1:0] data_in,
  output logic              req_out,
  input  logic              ack_out,
  output logic [SIZE-1:0]   data_out,
  output logic [N-1:0]      grant,
  output logic              busy
);

  localparam int LW = ptr_width(N);

  arb_state_e      state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   win_q, win_d;
  logic            req_out_q, req_out_d;
  logic [N-1:0]    ack_in_q, ack_in_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [SIZE-1:0] data_out_q, data_out_d;

  logic [N-1:0]    pending;
  logic            pick_valid;
  logic [LW-1:0]   pick_idx;

  // Configurations outside the supported range elaborate this marker block.
  if (N < 2 || N > 8 || ID < -1 || $bits(PORT) == 0) begin : g_cfg_out_of_range
  end

  assign pending = req_in ^ ack_in_q;

  rr_picker #(.N(N)) u_rr_picker (
    .pending (pending),
    .last    (last_q),
    .valid   (pick_valid),
    .winner  (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    req_out_d  = req_out_q;
    ack_in_d   = ack_in_q;
    grant_d    = grant_q;
    data_out_d = data_out_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          win_d             = pick_idx;
          data_out_d        = data_in[pick_idx*SIZE +: SIZE];
          req_out_d         = ~req_out_q;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (ack_out == req_out_q) begin
          ack_in_d[win_q] = ~ack_in_q[win_q];
          last_d          = win_q;
          grant_d         = '0;
          state_d         = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      last_q     <= LW'(N - 1);
      win_q      <= '0;
      req_out_q  <= 1'b0;
      ack_in_q   <= '0;
      grant_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      req_out_q  <= req_out_d;
      ack_in_q   <= ack_in_d;
      grant_q    <= grant_d;
      data_out_q <= data_out_d;
    end
  end

  assign req_out  = req_out_q;
  assign ack_in   = ack_in_q;
  assign grant    = grant_q;
  assign data_out = data_out_q;
  assign busy     = (state_q == ARB_WAIT);

`ifdef ARB_DEBUG_EN
  always @(posedge clk) begin
    if (!reset && state_q == ARB_IDLE && pick_valid)
      $display("%0t %0d %0s grant %0d %h", $time, ID, PORT, pick_idx, data_out_d);
    else if (!reset && state_q == ARB_WAIT && ack_out == req_out_q)
      $display("%0t %0d %0s release %0d %h", $time, ID, PORT, win_q, data_out_q);
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_channel_arbiter.sv
// ============================================================================
// Module      : tb_channel_arbiter
// Description : Directed self-checking bench for channel_arbiter (N=4, SIZE=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_arbiter;

  localparam int N    = 4;
  localparam int SIZE = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_in;
  logic [N-1:0]      ack_in;
  logic [N*SIZE-1:0] data_in;
  logic              req_out;
  logic              ack_out;
  logic [SIZE-1:0]   data_out;
  logic [N-1:0]      grant;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_ack;
  logic         exp_ro;

  channel_arbiter #(.ID(3), .PORT("east"), .SIZE(SIZE), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_in  (data_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .data_out (data_out),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".req_out"}, 32'(req_out), 32'(exp_ro));
    chk({tag, ".ack_in"},  32'(ack_in),  32'(exp_ack));
    chk({tag, ".grant"},   32'(grant),   32'h0);
    chk({tag, ".busy"},    32'(busy),    32'h0);
  endtask

  task automatic check_grant(input string tag, input int g, input logic [SIZE-1:0] d);
    chk({tag, ".req_out"},  32'(req_out),  32'(exp_ro));
    chk({tag, ".grant"},    32'(grant),    32'(1) << g);
    chk({tag, ".data_out"}, 32'(data_out), 32'(d));
    chk({tag, ".busy"},     32'(busy),     32'h1);
    chk({tag, ".ack_in"},   32'(ack_in),   32'(exp_ack));
  endtask

  task automatic send(input int g, input logic [SIZE-1:0] d);
    data_in[g*SIZE +: SIZE] = d;
    req_in[g] = ~req_in[g];
  endtask

  // Expects the arbiter idle with g the next round-robin winner; grants,
  // answers downstream immediately, and checks the release.
  task automatic serve(input string tag, input int g, input logic [SIZE-1:0] d);
    cyc();
    exp_ro = ~exp_ro;
    check_grant({tag, ".grant"}, g, d);
    ack_out = exp_ro;
    cyc();
    exp_ack[g] = ~exp_ack[g];
    check_idle({tag, ".release"});
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req_in  = '0;
    ack_out = 1'b0;
    data_in = '0;
    cyc();
    cyc();
    reset   = 1'b0;
    exp_ack = '0;
    exp_ro  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [4];

    // Reset values
    do_reset();
    check_idle("reset");
    chk("reset.data_out", 32'(data_out), 32'h0);

    // Single requester, including one-cycle grant latency
    send(2, 8'hA5);
    #1;
    chk("single.no_comb_grant", 32'(grant), 32'h0);
    chk("single.no_comb_req",   32'(req_out), 32'h0);
    serve("single", 2, 8'hA5);

    // All four pending after reset: 0,1,2,3, req_out toggles two cycles apart
    do_reset();
    for (int i = 0; i < N; i++) send(i, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < N; i++) serve("all4", i, 8'(8'h11 * (i + 1)));

    // Fairness between 1 and 3 with 1 served last: 3,1,3,1
    send(1, 8'h61);
    serve("fair.prime", 1, 8'h61);
    send(1, 8'h61);
    send(3, 8'h63);
    order = '{3, 1, 3, 1};
    for (int i = 0; i < 4; i++) begin
      serve("fair", order[i], (order[i] == 3) ? 8'h63 : 8'h61);
      if (i < 2) send(order[i], (order[i] == 3) ? 8'h63 : 8'h61);
    end

    // Stalled downstream for ten cycles
    send(0, 8'h5A);
    cyc();
    exp_ro = ~exp_ro;
    check_grant("stall.grant", 0, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_grant("stall.hold", 0, 8'h5A);
    end
    ack_out = exp_ro;
    cyc();
    exp_ack[0] = ~exp_ack[0];
    check_idle("stall.release");

    // Reset during WAIT abandons the transfer
    send(2, 8'hC3);
    cyc();
    exp_ro = ~exp_ro;
    check_grant("rstwait.grant", 2, 8'hC3);
    reset   = 1'b1;
    req_in  = '0;
    ack_out = 1'b0;
    cyc();
    exp_ack = '0;
    exp_ro  = 1'b0;
    check_idle("rstwait.reset");
    chk("rstwait.data_out", 32'(data_out), 32'h0);
    reset = 1'b0;
    send(0, 8'h0F);
    send(1, 8'hF1);
    serve("rstwait.fresh0", 0, 8'h0F);
    serve("rstwait.fresh1", 1, 8'hF1);

    // Wrap: last=3 with {0,2} pending picks 0
    send(3, 8'h33);
    serve("wrap.prime", 3, 8'h33);
    send(0, 8'hA0);
    send(2, 8'hA2);
    serve("wrap.first", 0, 8'hA0);
    serve("wrap.second", 2, 8'hA2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
